// File: rtl/ahb_master_dp_ctrl_pkg.sv
// AHB shared types for master-side ports.
// Transfer/response enums, data-phase FSM states, one-hot priority helper.
package AHB_package;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_type;

  typedef enum logic [1:0] {
    DP_IDLE = 2'b00,
    DP_SLV  = 2'b01,
    DP_ERR1 = 2'b10,
    DP_ERR2 = 2'b11
  } dp_state_type;

  localparam int MAX_SLV = 16;

  // Keep only the lowest set bit so overlapping maps resolve to one slave.
  function automatic logic [MAX_SLV-1:0] lowest_onehot(
    input logic [MAX_SLV-1:0] req
  );
    logic [MAX_SLV-1:0] res;
    logic               found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_SLV; i++) begin
      if (req[i] && !found) begin
        res[i] = 1'b1;
        found  = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ahb_master_dp_ctrl_default_slave.sv
// Built-in default slave for unmapped accesses.
// Two-cycle ERROR: first cycle not ready, second cycle ready.
module ahb_default_slave
  import AHB_package::*;
(
  input  logic      hclk,
  input  logic      hreset_n,
  input  logic      start,
  output logic      hready,
  output hresp_type hresp,
  output logic      busy
);

  dp_state_type r_state;
  dp_state_type w_next;

  // ERROR sequence state register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) r_state <= DP_IDLE;
    else           r_state <= w_next;
  end

  // Sequencing and response outputs
  always_comb begin
    w_next = r_state;
    hready = 1'b1;
    hresp  = OKAY;
    busy   = 1'b0;
    case (r_state)
      DP_ERR1: begin
        w_next = DP_ERR2;
        hready = 1'b0;
        hresp  = ERROR;
        busy   = 1'b1;
      end
      DP_ERR2: begin
        w_next = start ? DP_ERR1 : DP_IDLE;
        hresp  = ERROR;
        busy   = 1'b1;
      end
      default: begin
        w_next = start ? DP_ERR1 : DP_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ahb_master_dp_ctrl.sv
// Per-master data-phase controller.
// Holds address phase until granted, then muxes the owning slave's response.
module ahb_master_dp_ctrl
  import AHB_package::*;
#(
  parameter int AHB_DATA_WIDTH     = 32,
  parameter int MASTER_X_SLAVE_NUM = 2
) (
  input  logic                hclk,
  input  logic                hreset_n,
  input  htrans_type          htrans,
  input  logic [MASTER_X_SLAVE_NUM-1:0] hreq,
  input  logic                default_slv_sel,
  input  logic [MASTER_X_SLAVE_NUM-1:0] hgrant,
  input  logic [MASTER_X_SLAVE_NUM-1:0] slv_hready,
  input  logic [MASTER_X_SLAVE_NUM-1:0][1:0] slv_hresp,
  input  logic [MASTER_X_SLAVE_NUM-1:0][AHB_DATA_WIDTH-1:0] slv_hrdata,
  output logic                hready,
  output hresp_type           hresp,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  output logic [MASTER_X_SLAVE_NUM-1:0] dp_sel
);

  localparam int N = MASTER_X_SLAVE_NUM;
  localparam int W = AHB_DATA_WIDTH;

  dp_state_type r_state;
  dp_state_type w_next;
  logic [N-1:0] r_dp_sel;

  logic         w_active;
  logic [N-1:0] w_req;
  logic         w_def;
  logic [N-1:0] w_sel;
  logic         w_dp_done;
  logic         w_accept;
  logic         w_ds_start;
  logic         w_ds_hready;
  hresp_type    w_ds_hresp;
  logic         w_ds_busy;
  logic         w_slv_rdy;
  logic [1:0]   w_slv_resp;
  logic [W-1:0] w_slv_data;

  // The decoder only requests on active transfers; masking keeps a stray
  // request during IDLE/BUSY from stalling the master.
  assign w_active = (htrans == NONSEQ) || (htrans == SEQ);
  assign w_req    = hreq & {N{w_active}};
  assign w_def    = default_slv_sel & w_active;
  assign w_sel    = N'(lowest_onehot(MAX_SLV'(w_req)));

  assign w_accept   = w_dp_done && !(|(w_req & ~hgrant));
  assign w_ds_start = w_accept && !(|w_req) && w_def;

  assign hready = w_accept;
  assign dp_sel = r_dp_sel;

  ahb_default_slave u_dflt (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .start    (w_ds_start),
    .hready   (w_ds_hready),
    .hresp    (w_ds_hresp),
    .busy     (w_ds_busy)
  );

  // Data-phase state and registered slave select
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      r_state  <= DP_IDLE;
      r_dp_sel <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != DP_SLV) r_dp_sel <= '0;
      else if (w_accept)    r_dp_sel <= w_sel;
    end
  end

  // Selected-slave response gather (dp_sel is one-hot or zero)
  always_comb begin
    w_slv_rdy  = 1'b0;
    w_slv_resp = '0;
    w_slv_data = '0;
    for (int i = 0; i < N; i++) begin
      if (r_dp_sel[i]) begin
        w_slv_rdy  = w_slv_rdy | slv_hready[i];
        w_slv_resp = w_slv_resp | slv_hresp[i];
        w_slv_data = w_slv_data | slv_hrdata[i];
      end
    end
  end

  // Completion, response mux and next state
  always_comb begin
    w_dp_done = 1'b1;
    hresp     = OKAY;
    hrdata    = '0;
    w_next    = r_state;
    case (r_state)
      DP_SLV: begin
        w_dp_done = w_slv_rdy;
        hresp     = hresp_type'(w_slv_resp);
        hrdata    = w_slv_data;
      end
      DP_ERR1, DP_ERR2: begin
        w_dp_done = w_ds_hready && w_ds_busy;
        hresp     = w_ds_hresp;
      end
      default: begin
        w_dp_done = 1'b1;
      end
    endcase
    if (w_accept) begin
      if (|w_req)     w_next = DP_SLV;
      else if (w_def) w_next = DP_ERR1;
      else            w_next = DP_IDLE;
    end else begin
      case (r_state)
        DP_ERR1: w_next = DP_ERR2;
        DP_ERR2: w_next = DP_IDLE;
        DP_SLV:  w_next = w_dp_done ? DP_IDLE : DP_SLV;
        default: w_next = DP_IDLE;
      endcase
    end
  end

endmodule
